reprogram_framed: RTL and testbench

Parametrised framed loader that turns a byte stream (from the UART receive path) into word writes for the program/boot RAM. It adds over the first-generation loader:
- an explicit frame with sync byte, start address and word count;
- configurable word width and byte order;
- an optional XOR checksum trailer with done/error reporting.

It sits between the UART receiver byte FIFO and the RAM write port, all in the `clk_50mhz` domain.

---
 rtl/reprogram_framed.sv | 205 ++++++++++++++++++++
 tb/tb_reprogram_framed.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reprogram_framed.sv
`default_nettype none
// ============================================================================
// Module   : reprogram_framed
// Purpose  : Framed byte-stream loader producing word writes for the boot RAM.
//            Optional checksum trailer enabled by macro REPROGRAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reprogram_framed #(
  parameter int         ADDR_W     = 13,
  parameter int         WORD_BYTES = 4,
  parameter bit         BIG_ENDIAN = 0,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                    clk_50mhz,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*WORD_BYTES-1:0] data,
  output logic                    write,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              xorc
);

  localparam int         c_data_w    = 8 * WORD_BYTES;
  localparam logic [1:0] c_last_byte = 2'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
`ifdef REPROGRAM_CHECKSUM_EN
    S_DATA = 2'd2,
    S_CHK  = 2'd3
`else
    S_DATA = 2'd2
`endif
  } state_t;

  state_t              r_state;
  logic [1:0]          r_hdr_cnt;
  logic [1:0]          r_byte_cnt;
  logic [7:0]          r_start_lo;
  logic [7:0]          r_start_hi;
  logic [7:0]          r_cnt_lo;
  logic [15:0]         r_cnt;
  logic [15:0]         r_word_cnt;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [c_data_w-1:0] r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_data_w-1:0] r_data;
  logic                r_write;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_xorc;

  logic                w_fire;
  logic [c_data_w-1:0] w_next_word;
  logic [15:0]         w_word_cnt_nxt;
  logic [15:0]         w_hdr_cnt16;

  assign in_ready       = ~rst;
  assign w_fire         = in_valid & in_ready;
  assign w_word_cnt_nxt = r_word_cnt + 16'd1;
  assign w_hdr_cnt16    = {in_data, r_cnt_lo};

  // Word assembly: little-endian shifts right so the first byte lands in [7:0].
  generate
    if (WORD_BYTES == 1) begin : g_single
      assign w_next_word = in_data;
    end else if (BIG_ENDIAN) begin : g_big
      assign w_next_word = {r_shift[c_data_w-9:0], in_data};
    end else begin : g_little
      assign w_next_word = {in_data, r_shift[c_data_w-1:8]};
    end
  endgenerate

  assign addr  = r_addr;
  assign data  = r_data;
  assign write = r_write;
  assign busy  = r_busy;
  assign done  = r_done;
  assign xorc  = r_xorc;

`ifdef REPROGRAM_CHECKSUM_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_byte_cnt  <= 2'd0;
      r_start_lo  <= 8'd0;
      r_start_hi  <= 8'd0;
      r_cnt_lo    <= 8'd0;
      r_cnt       <= 16'd0;
      r_word_cnt  <= 16'd0;
      r_next_addr <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_xorc      <= 8'd0;
`ifdef REPROGRAM_CHECKSUM_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      if (w_fire) begin
        case (r_state)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              r_state   <= S_HDR;
              r_hdr_cnt <= 2'd0;
              r_xorc    <= 8'd0;
              r_busy    <= 1'b1;
`ifdef REPROGRAM_CHECKSUM_EN
              r_err     <= 1'b0;
`endif
            end
          end

          S_HDR: begin
            r_xorc    <= r_xorc ^ in_data;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0: r_start_lo <= in_data;
              2'd1: r_start_hi <= in_data;
              2'd2: r_cnt_lo   <= in_data;
              default: begin
                r_cnt       <= w_hdr_cnt16;
                r_next_addr <= ADDR_W'({r_start_hi, r_start_lo});
                r_word_cnt  <= 16'd0;
                r_byte_cnt  <= 2'd0;
                r_shift     <= '0;
                if (w_hdr_cnt16 != 16'd0) begin
                  r_state <= S_DATA;
                end else begin
`ifdef REPROGRAM_CHECKSUM_EN
                  r_state <= S_CHK;
`else
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
`endif
                end
              end
            endcase
          end

          S_DATA: begin
            r_xorc <= r_xorc ^ in_data;
            if (r_byte_cnt == c_last_byte) begin
              r_addr      <= r_next_addr;
              r_data      <= w_next_word;
              r_write     <= 1'b1;
              r_next_addr <= r_next_addr + 1'b1;
              r_word_cnt  <= w_word_cnt_nxt;
              r_byte_cnt  <= 2'd0;
              r_shift     <= '0;
              if (w_word_cnt_nxt == r_cnt) begin
`ifdef REPROGRAM_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
`endif
              end
            end else begin
              r_shift    <= w_next_word;
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end

`ifdef REPROGRAM_CHECKSUM_EN
          S_CHK: begin
            // Payload already written; a mismatch is only reported.
            if (in_data == r_xorc) begin
              r_done <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`endif

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reprogram_framed.sv
`default_nettype none
// ============================================================================
// Module   : tb_reprogram_framed
// Purpose  : Directed self-checking bench for reprogram_framed (LE and BE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reprogram_framed;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        le_ready, le_write, le_busy, le_done, le_err;
  logic [12:0] le_addr;
  logic [31:0] le_data;
  logic [7:0]  le_xorc;
  logic        be_ready, be_write, be_busy, be_done, be_err;
  logic [12:0] be_addr;
  logic [31:0] be_data;
  logic [7:0]  be_xorc;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [12:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wbe_q[$];

  always #10 clk = ~clk;

  reprogram_framed #(.ADDR_W(13), .WORD_BYTES(4), .BIG_ENDIAN(0), .SYNC_BYTE(8'hA5)) u_le (
    .clk_50mhz(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(le_ready),
    .addr(le_addr), .data(le_data), .write(le_write), .busy(le_busy), .done(le_done),
    .err(le_err), .xorc(le_xorc)
  );

  reprogram_framed #(.ADDR_W(13), .WORD_BYTES(4), .BIG_ENDIAN(1), .SYNC_BYTE(8'hA5)) u_be (
    .clk_50mhz(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(be_ready),
    .addr(be_addr), .data(be_data), .write(be_write), .busy(be_busy), .done(be_done),
    .err(be_err), .xorc(be_xorc)
  );

  always @(negedge clk) begin
    if (le_write) begin
      wa_q.push_back(le_addr);
      wd_q.push_back(le_data);
    end
    if (be_write) wbe_q.push_back(be_data);
    if (le_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic hdr(input logic [15:0] a, input logic [15:0] c);
    send(8'hA5);
    send(a[7:0]);
    send(a[15:8]);
    send(c[7:0]);
    send(c[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wbe_q.delete();
    done_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(le_addr), 32'h0);
    chk({tag, "_data"},  le_data, 32'h0);
    chk({tag, "_write"}, 32'(le_write), 32'h0);
    chk({tag, "_busy"},  32'(le_busy), 32'h0);
    chk({tag, "_done"},  32'(le_done), 32'h0);
    chk({tag, "_err"},   32'(le_err), 32'h0);
    chk({tag, "_xorc"},  32'(le_xorc), 32'h0);
    chk({tag, "_be_data"}, be_data, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_ready", 32'(le_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready", 32'(le_ready), 32'h1);
    chk("ready_be", 32'(be_ready), 32'h1);

    // Garbage before any sync is dropped silently.
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(3);
    chk("garb_writes", 32'(wa_q.size()), 32'd0);
    chk("garb_busy", 32'(le_busy), 32'h0);
    chk("garb_xorc", 32'(le_xorc), 32'h0);
    chk("garb_done", 32'(done_cnt), 32'd0);

    // Frame A, immediately followed by a wrap-around frame.
    clear_log();
    hdr(16'h0010, 16'd2);
    send_word(32'h44332211);
    send_word(32'h88776655);
`ifdef REPROGRAM_CHECKSUM_EN
    send(8'h9A);
`endif
    send(8'hA5);
    chk("a_done", 32'(le_done), 32'h1);
    chk("a_busy", 32'(le_busy), 32'h0);
    chk("a_xorc", 32'(le_xorc), 32'h9A);
    chk("a_err", 32'(le_err), 32'h0);
`ifdef REPROGRAM_CHECKSUM_EN
    chk("a_write_after_chk", 32'(le_write), 32'h0);
`else
    chk("a_write_with_done", 32'(le_write), 32'h1);
`endif
    send(8'hFF);
    chk("b_busy", 32'(le_busy), 32'h1);
    chk("b_xorc_clr", 32'(le_xorc), 32'h0);
    chk("b_done_clr", 32'(le_done), 32'h0);
    send(8'h1F); send(8'h02); send(8'h00);
    send_word(32'h04030201);
    send_word(32'h08070605);
`ifdef REPROGRAM_CHECKSUM_EN
    send(8'hEA);
`endif
    idle(3);
    chk("ab_nwrites", 32'(wa_q.size()), 32'd4);
    chk("ab_nbe", 32'(wbe_q.size()), 32'd4);
    if (wa_q.size() == 4 && wbe_q.size() == 4) begin
      chk("a_addr0", 32'(wa_q[0]), 32'h010);
      chk("a_data0", wd_q[0], 32'h44332211);
      chk("a_be0",   wbe_q[0], 32'h11223344);
      chk("a_addr1", 32'(wa_q[1]), 32'h011);
      chk("a_data1", wd_q[1], 32'h88776655);
      chk("a_be1",   wbe_q[1], 32'h55667788);
      chk("b_addr0", 32'(wa_q[2]), 32'h1FFF);
      chk("b_data0", wd_q[2], 32'h04030201);
      chk("b_addr1", 32'(wa_q[3]), 32'h0000);
      chk("b_data1", wd_q[3], 32'h08070605);
    end
    chk("ab_done_cnt", 32'(done_cnt), 32'd2);
    chk("b_xorc", 32'(le_xorc), 32'hEA);
    chk("b_busy_end", 32'(le_busy), 32'h0);
    chk("b_addr_hold", 32'(le_addr), 32'h0000);
    chk("b_data_hold", le_data, 32'h08070605);

`ifdef REPROGRAM_CHECKSUM_EN
    // Bad checksum: writes stay, err sets; next sync clears err.
    clear_log();
    hdr(16'h0010, 16'd2);
    send_word(32'h44332211);
    send_word(32'h88776655);
    send(8'h00);
    send(8'hA5);
    chk("bad_err", 32'(le_err), 32'h1);
    chk("bad_done", 32'(le_done), 32'h0);
    chk("bad_busy", 32'(le_busy), 32'h0);
    send(8'h10);
    chk("sync_clr_err", 32'(le_err), 32'h0);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h10);
    idle(3);
    chk("bad_nwrites", 32'(wa_q.size()), 32'd2);
    chk("cnt0_ok_done", 32'(done_cnt), 32'd1);
    chk("cnt0_ok_err", 32'(le_err), 32'h0);
    chk("cnt0_xorc", 32'(le_xorc), 32'h10);
    clear_log();
    hdr(16'h0010, 16'd0);
    send(8'h00);
    idle(3);
    chk("cnt0_bad_err", 32'(le_err), 32'h1);
    chk("cnt0_bad_done", 32'(done_cnt), 32'd0);
    chk("cnt0_bad_writes", 32'(wa_q.size()), 32'd0);
`else
    clear_log();
    hdr(16'h0010, 16'd0);
    idle(3);
    chk("cnt0_done", 32'(done_cnt), 32'd1);
    chk("cnt0_writes", 32'(wa_q.size()), 32'd0);
    chk("cnt0_xorc", 32'(le_xorc), 32'h10);
    chk("cnt0_err", 32'(le_err), 32'h0);
`endif

    // Reset after two payload bytes aborts the frame.
    clear_log();
    hdr(16'h0010, 16'd1);
    send(8'h11); send(8'h22);
    idle(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrst");
    chk("midrst_writes", 32'(wa_q.size()), 32'd0);
    rst = 1'b0;
    hdr(16'h0020, 16'd1);
    send_word(32'hDDCCBBAA);
`ifdef REPROGRAM_CHECKSUM_EN
    send(8'h21);
`endif
    idle(3);
    chk("post_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1 && wbe_q.size() == 1) begin
      chk("post_addr", 32'(wa_q[0]), 32'h020);
      chk("post_data", wd_q[0], 32'hDDCCBBAA);
      chk("post_be",   wbe_q[0], 32'hAABBCCDD);
    end
    chk("post_done", 32'(done_cnt), 32'd1);
    chk("post_xorc", 32'(le_xorc), 32'h21);
    chk("post_be_xorc", 32'(be_xorc), 32'h21);
    chk("post_be_busy", 32'(be_busy), 32'h0);
    chk("post_be_err", 32'(be_err), 32'h0);
    chk("post_be_done", 32'(be_done), 32'h0);
    chk("post_be_addr", 32'(be_addr), 32'h020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
